// File: rtl/ig_recon_pkg.sv
// Shared constants, state encoding and gradient-word field positions for ig_recon.
// IMG_W/IMG_H here are defaults only; the top module overrides them per instance.
package ig_pkg;

    localparam int DEF_IMG_W = 256;
    localparam int DEF_IMG_H = 256;
    localparam int PIX_W     = 8;
    localparam int G_W       = 10;
    localparam int GRAD_W    = 2 * G_W;
    localparam int ADDR_W    = 16;

    localparam int GX_MSB = 2 * G_W - 1;
    localparam int GX_LSB = G_W;
    localparam int GY_MSB = G_W - 1;
    localparam int GY_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        CHAIN,
        TAIL,
        LAST,
        DONE
    } state_t;

endpackage

// File: rtl/ig_recon_if.sv
// Gradient-memory read port and image-memory write port seen by ig_recon.
// Reads are asynchronous: grad_di follows grad_addr within the same cycle.
interface ig_recon_if;
    import ig_pkg::*;

    logic              grad_rd;
    logic [ADDR_W-1:0] grad_addr;
    logic [GRAD_W-1:0] grad_di;
    logic              img_wr;
    logic [ADDR_W-1:0] img_addr;
    logic [PIX_W-1:0]  img_do;

    modport master (
        output grad_rd, grad_addr, img_wr, img_addr, img_do,
        input  grad_di
    );

    modport slave (
        input  grad_rd, grad_addr, img_wr, img_addr, img_do,
        output grad_di
    );

endinterface

// File: rtl/ig_recon_add_sat.sv
// Unsigned pixel plus signed gradient, evaluated at G_W+1 bits.
// Wraps modulo 2^PIX_W by default; IG_RECON_SAT_EN clamps and reports the clamp.
module ig_add_sat
    import ig_pkg::*;
(
    input  logic        [PIX_W-1:0] pix_i,
    input  logic signed [G_W-1:0]   grad_i,
`ifdef IG_RECON_SAT_EN
    output logic                    sat_o,
`endif
    output logic        [PIX_W-1:0] sum_o
);

    localparam int SW = G_W + 1;

    logic signed [SW-1:0] sum;

    assign sum = $signed({{(SW-PIX_W){1'b0}}, pix_i}) + $signed({grad_i[G_W-1], grad_i});

`ifdef IG_RECON_SAT_EN
    localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << PIX_W) - 1);

    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [SW-1:0] s);
        if (s < 0)
            return '0;
        if (s > PIX_MAX)
            return '1;
        return s[PIX_W-1:0];
    endfunction

    assign sum_o = clamp_pix(sum);
    assign sat_o = (sum < 0) || (sum > PIX_MAX);
`else
    function automatic logic [PIX_W-1:0] wrap_pix(input logic signed [SW-1:0] s);
        return s[PIX_W-1:0];
    endfunction

    assign sum_o = wrap_pix(sum);
`endif

endmodule

// File: rtl/ig_recon.sv
// ig_recon: rebuilds an IMG_W x IMG_H image from packed {gx,gy} gradients and a seed pixel.
// Define IG_RECON_SAT_EN to clamp sums instead of wrapping and keep a sticky sat_seen flag.
module ig_recon
    import ig_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] seed,
    ig_recon_if.master       bus,
    output logic             done
);

    localparam int N = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] CHAIN_END = ADDR_W'(N - 2 * IMG_W);
    localparam logic [ADDR_W-1:0] TAIL_END  = ADDR_W'(N - IMG_W - 2);
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] ROW       = ADDR_W'(IMG_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [PIX_W-1:0]  acc_q, acc_d;
    logic [PIX_W-1:0]  base_q, base_d;
    logic              grad_rd_q, grad_rd_d;
    logic [ADDR_W-1:0] grad_addr_q, grad_addr_d;
    logic              img_wr_q, img_wr_d;
    logic [ADDR_W-1:0] img_addr_q, img_addr_d;
    logic [PIX_W-1:0]  img_do_q, img_do_d;
    logic              done_q, done_d;

    logic signed [G_W-1:0] gx, gy;
    logic [PIX_W-1:0]      chain_sum, tail_sum;

    assign gx = $signed(bus.grad_di[GX_MSB:GX_LSB]);
    assign gy = $signed(bus.grad_di[GY_MSB:GY_LSB]);

`ifdef IG_RECON_SAT_EN
    logic chain_sat, tail_sat;
    logic sat_seen_q;
`endif

    // Chain path extends the running pixel along the row-major scan; tail path fills the last row from above.
    ig_add_sat u_chain_add (
        .pix_i  (acc_q),
        .grad_i (gx),
`ifdef IG_RECON_SAT_EN
        .sat_o  (chain_sat),
`endif
        .sum_o  (chain_sum)
    );

    ig_add_sat u_tail_add (
        .pix_i  (base_q),
        .grad_i (gy),
`ifdef IG_RECON_SAT_EN
        .sat_o  (tail_sat),
`endif
        .sum_o  (tail_sum)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        acc_d       = acc_q;
        base_d      = base_q;
        grad_rd_d   = grad_rd_q;
        grad_addr_d = grad_addr_q;
        img_wr_d    = 1'b0;
        img_addr_d  = img_addr_q;
        img_do_d    = img_do_q;
        done_d      = done_q;

        case (state_q)
            IDLE: state_d = SEED;
            SEED: begin
                img_wr_d    = 1'b1;
                img_addr_d  = '0;
                img_do_d    = seed;
                acc_d       = seed;
                grad_rd_d   = 1'b1;
                grad_addr_d = '0;
                a_d         = '0;
                state_d     = CHAIN;
            end
            CHAIN: begin
                img_wr_d   = 1'b1;
                img_addr_d = a_q + 16'd1;
                img_do_d   = chain_sum;
                acc_d      = chain_sum;
                base_d     = acc_q;
                if (a_q < CHAIN_END) begin
                    a_d         = a_q + 16'd1;
                    grad_addr_d = a_q + 16'd1;
                end else begin
                    state_d = TAIL;
                end
            end
            TAIL: begin
                img_wr_d   = 1'b1;
                img_addr_d = a_q + ROW;
                img_do_d   = tail_sum;
                // The final last-row source has no chain successor: the only pixel left is N-1.
                if (a_q == TAIL_END) begin
                    grad_rd_d = 1'b0;
                    state_d   = LAST;
                end else begin
                    a_d         = a_q + 16'd1;
                    grad_addr_d = a_q + 16'd1;
                    state_d     = CHAIN;
                end
            end
            LAST: begin
                img_wr_d   = 1'b1;
                img_addr_d = LAST_PIX;
                img_do_d   = '0;
                grad_rd_d  = 1'b0;
                state_d    = DONE;
            end
            DONE: done_d = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            acc_q       <= '0;
            grad_rd_q   <= 1'b0;
            grad_addr_q <= '0;
            img_wr_q    <= 1'b0;
            img_addr_q  <= '0;
            img_do_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            grad_rd_q   <= grad_rd_d;
            grad_addr_q <= grad_addr_d;
            img_wr_q    <= img_wr_d;
            img_addr_q  <= img_addr_d;
            img_do_q    <= img_do_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        base_q <= base_d;
    end

`ifdef IG_RECON_SAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_seen_q <= 1'b0;
        else if ((state_q == CHAIN && chain_sat) || (state_q == TAIL && tail_sat))
            sat_seen_q <= 1'b1;
    end
`endif

    assign bus.grad_rd   = grad_rd_q;
    assign bus.grad_addr = grad_addr_q;
    assign bus.img_wr    = img_wr_q;
    assign bus.img_addr  = img_addr_q;
    assign bus.img_do    = img_do_q;
    assign done          = done_q;

endmodule

// File: tb/tb_ig_recon.sv
// Bench for ig_recon on a 16x8 image: gradient memory model, image memory, and a
// reference built from the pixel recurrences, checked on every image write.
module tb_ig_recon;
    import ig_pkg::*;

    localparam int W = 16;
    localparam int H = 8;
    localparam int N = W * H;
    localparam int PMAX = (1 << PIX_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [PIX_W-1:0] seed = '0;
    logic             done;

    ig_recon_if bus ();

    ig_recon #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .reset (reset),
        .seed  (seed),
        .bus   (bus),
        .done  (done)
    );

    always #5 clk = ~clk;

    logic [GRAD_W-1:0] gmem [0:65535];
    logic [PIX_W-1:0]  imem [0:65535];

    assign bus.grad_di = gmem[bus.grad_addr];

    always @(posedge clk) begin
        if (bus.img_wr === 1'b1)
            imem[bus.img_addr] <= bus.img_do;
    end

    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int addr;
        int data;
        int rd;
        int gaddr;
        bit chkga;
    } wr_t;

    wr_t q[$];
    int  x    [0:N-1];
    int  expv [0:N-1];
    int  errors = 0;
    int  checks = 0;
    bit  checking = 1'b0;
    bit  done_seen = 1'b0;
    int  done_cyc = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int fold(input int v);
`ifdef IG_RECON_SAT_EN
        if (v < 0) return 0;
        if (v > PMAX) return PMAX;
        return v;
`else
        return v & PMAX;
`endif
    endfunction

    function automatic int get_gx(input int a);
        logic [GRAD_W-1:0] w;
        w = gmem[16'(a)];
        return int'($signed(w[GX_MSB:GX_LSB]));
    endfunction

    function automatic int get_gy(input int a);
        logic [GRAD_W-1:0] w;
        w = gmem[16'(a)];
        return int'($signed(w[GY_MSB:GY_LSB]));
    endfunction

    function automatic void set_g(input int a, input int gxv, input int gyv);
        gmem[16'(a)] = {G_W'(gxv), G_W'(gyv)};
    endfunction

    // What the gradient block would produce for image x.
    function automatic void encode();
        for (int a = 0; a < N; a++) begin
            if (a < N - W) set_g(a, x[a+1] - x[a], x[a+W] - x[a]);
            else           set_g(a, 0, 0);
        end
    endfunction

    // Expected pixels from the recurrences, then the write order with its grad-port state.
    function automatic void build_expect(input int s);
        wr_t e;
        expv[0] = s;
        for (int p = 1; p <= N - W - 1; p++) expv[p] = fold(expv[p-1] + get_gx(p-1));
        for (int a = N - 2*W; a <= N - W - 2; a++) expv[a+W] = fold(expv[a] + get_gy(a));
        expv[N-1] = 0;
        q.delete();
        e = '{addr: 0, data: s, rd: 1, gaddr: 0, chkga: 1'b1};
        q.push_back(e);
        for (int a = 0; a <= N - W - 2; a++) begin
            e = '{addr: a+1, data: expv[a+1], rd: 1, gaddr: (a < N - 2*W) ? a + 1 : a, chkga: 1'b1};
            q.push_back(e);
            if (a >= N - 2*W) begin
                e = '{addr: a+W, data: expv[a+W], rd: (a != N - W - 2) ? 1 : 0,
                      gaddr: a + 1, chkga: (a != N - W - 2)};
                q.push_back(e);
            end
        end
        e = '{addr: N-1, data: 0, rd: 0, gaddr: 0, chkga: 1'b0};
        q.push_back(e);
        done_seen = 1'b0;
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (checking && reset === 1'b0) begin
            if (bus.img_wr === 1'b1) begin
                chk("wr_while_done", int'(done), 0);
                if (q.size() == 0) begin
                    chk("extra_write", int'(bus.img_addr), -1);
                end else begin
                    e = q.pop_front();
                    chk("wr_addr", int'(bus.img_addr), e.addr);
                    chk("wr_data", int'(bus.img_do), e.data);
                    chk("wr_grad_rd", int'(bus.grad_rd), e.rd);
                    if (e.chkga) chk("wr_grad_addr", int'(bus.grad_addr), e.gaddr);
                end
            end
            if (done === 1'b1 && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                chk("done_cycle", cyc, N + 2);
                chk("writes_left", q.size(), 0);
            end
        end
    end

    task automatic start_run(input int s);
        @(negedge clk);
        reset = 1'b1;
        seed  = PIX_W'(s);
        build_expect(s);
        checking = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < N + 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", int'(done === 1'b1), 1);
        repeat (3) @(negedge clk);
        chk("done_sticky", int'(done), 1);
        chk("wr_after_done", int'(bus.img_wr), 0);
        chk("rd_after_done", int'(bus.grad_rd), 0);
    endtask

    task automatic image_match(input string name);
        int mism = 0;
        for (int p = 0; p < N - 1; p++)
            if (int'(imem[16'(p)]) != x[p]) mism++;
        chk(name, mism, 0);
        chk({name, "_last"}, int'(imem[16'(N-1)]), 0);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_img_wr"}, int'(bus.img_wr), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_grad_rd"}, int'(bus.grad_rd), 0);
        chk({name, "_grad_addr"}, int'(bus.grad_addr), 0);
        chk({name, "_img_addr"}, int'(bus.img_addr), 0);
        chk({name, "_img_do"}, int'(bus.img_do), 0);
    endtask

    initial begin
        int mism;
        for (int a = 0; a < 65536; a++) gmem[a] = '0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");

        // Flat image
        for (int a = 0; a < N; a++) x[a] = 8'h37;
        encode();
        start_run(8'h37);
        wait_done();
        chk("flat_pix5", int'(imem[16'd5]), 8'h37);
        chk("flat_tail", int'(imem[16'(N-W)]), 8'h37);
        chk("flat_last", int'(imem[16'(N-1)]), 0);
        chk("flat_done_cyc", done_cyc, 130);
        image_match("flat_image");

        // Horizontal ramp with a wrap at a = 56
        for (int a = 0; a < N; a++) x[a] = (a + 200) & PMAX;
        encode();
        start_run(200);
        wait_done();
        chk("ramp_pix55", int'(imem[16'd55]), 255);
        chk("ramp_pix56", int'(imem[16'd56]), 0);
        image_match("ramp_image");

        // Random round trip
        for (int a = 0; a < N; a++) x[a] = int'($urandom_range(0, PMAX));
        encode();
        start_run(x[0]);
        wait_done();
        image_match("rand_image");
`ifdef IG_RECON_SAT_EN
        chk("rand_sat_seen", int'(dut.sat_seen_q), 0);
`endif

        // Last row driven by gy = +5
        for (int a = 0; a < N; a++) x[a] = int'($urandom_range(0, PMAX));
        x[N-2*W] = 8'h10;
        encode();
        for (int a = N - 2*W; a <= N - W - 2; a++) set_g(a, get_gx(a), 5);
        start_run(x[0]);
        wait_done();
        chk("lastrow_pin", int'(imem[16'(N-W)]), 8'h15);
        mism = 0;
        for (int a = N - 2*W; a <= N - W - 2; a++)
            if (int'(imem[16'(a+W)]) != fold(x[a] + 5)) mism++;
        chk("lastrow_all", mism, 0);

        // Inconsistent gradients: 250 + 10
        for (int a = 0; a < N; a++) set_g(a, 0, 0);
        set_g(0, 10, 0);
        start_run(250);
        wait_done();
`ifdef IG_RECON_SAT_EN
        chk("incons_pix1", int'(imem[16'd1]), 255);
        chk("incons_sat_seen", int'(dut.sat_seen_q), 1);
`else
        chk("incons_pix1", int'(imem[16'd1]), 4);
`endif
        chk("incons_pix2", int'(imem[16'd2]), int'(imem[16'd1]));

        // Reset in the middle of a run, then a full rerun
        for (int a = 0; a < N; a++) x[a] = int'($urandom_range(0, PMAX));
        encode();
        start_run(x[0]);
        repeat (60) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_idle_outputs("midreset");
        repeat (3) @(negedge clk);
        build_expect(x[0]);
        reset = 1'b0;
        wait_done();
        image_match("rerun_image");

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
